aiv_video_timing: RTL and testbench

Downstream stage of the AIV sync separator. It consumes the regenerated hsync pulse and vsync level plus the synchronised RGB111 inputs, and maintains pixel and line counters in the Pi pixel-clock domain. It detects odd/even field, qualifies lock against the PAL line count, and drives blanked RGB666 with active-window coordinates toward the SCART output stage.

---
 rtl/aiv_video_timing.sv | 160 ++++++++++++++++
 tb/tb_aiv_video_timing.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/aiv_video_timing.sv
// Pixel/line counters, field detection, PAL line-count lock qualification and
// blanked RGB666 generation with active-window coordinates.
module aiv_video_timing #(
  parameter int unsigned H_ACTIVE_START = 120,
  parameter int unsigned H_ACTIVE       = 640,
  parameter int unsigned V_ACTIVE_START = 23,
  parameter int unsigned V_ACTIVE       = 256,
  parameter int unsigned HALF_LINE      = 384,
  parameter int unsigned LINES_MIN      = 310,
  parameter int unsigned LINES_MAX      = 314
) (
  input  logic       sysClock,
  input  logic       nReset,
  input  logic       pixelClockX1_en,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       redIn,
  input  logic       greenIn,
  input  logic       blueIn,
  output logic [5:0] red_out,
  output logic [5:0] green_out,
  output logic [5:0] blue_out,
  output logic       active,
  output logic [9:0] pixelX,
  output logic [8:0] pixelY,
  output logic       field,
  output logic       locked
);

  localparam int unsigned HW = 10;
  localparam int unsigned VW = 9;
  localparam logic [HW-1:0] H_MAX = '1;
  localparam logic [VW-1:0] V_MAX = '1;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } lock_state_t;

  lock_state_t   state, state_nxt;
  logic          locked_nxt;
  logic          vsync_q;
  logic          vs_rise;
  logic          good_field;
  logic          in_win;
  logic          win_active;
  logic [HW-1:0] h_count, h_nxt, h_eff;
  logic [VW-1:0] v_count, v_nxt;
  logic [VW-1:0] last_lines;

  // Counter next values; hsync and vsync rise take priority, both saturate
  always_comb begin
    h_nxt = h_count;
    v_nxt = v_count;
    if (hsync) begin
      h_nxt = '0;
    end else if (pixelClockX1_en && (h_count != H_MAX)) begin
      h_nxt = h_count + HW'(1);
    end
    if (vs_rise) begin
      v_nxt = '0;
    end else if (hsync && (v_count != V_MAX)) begin
      v_nxt = v_count + VW'(1);
    end
  end

  assign vs_rise    = vsync & ~vsync_q;
  assign h_eff      = hsync ? '0 : h_count;
  assign good_field = (v_count >= VW'(LINES_MIN)) && (v_count <= VW'(LINES_MAX));

  assign in_win = (h_count >= HW'(H_ACTIVE_START)) &&
                  (h_count <  HW'(H_ACTIVE_START + H_ACTIVE)) &&
                  (v_count >= VW'(V_ACTIVE_START)) &&
                  (v_count <  VW'(V_ACTIVE_START + V_ACTIVE));
  assign win_active = in_win && (state == LOCKED);

  // Counters, vsync edge detect, field and line-count capture
  always_ff @(posedge sysClock or negedge nReset) begin
    if (!nReset) begin
      h_count    <= '0;
      v_count    <= '0;
      vsync_q    <= 1'b0;
      last_lines <= '0;
      field      <= 1'b0;
    end else begin
      h_count <= h_nxt;
      v_count <= v_nxt;
      vsync_q <= vsync;
      if (vs_rise) begin
        last_lines <= v_count;
        field      <= (h_eff >= HW'(HALF_LINE));
      end
    end
  end

  // Lock FSM state register
  always_ff @(posedge sysClock or negedge nReset) begin
    if (!nReset) begin
      state  <= SEARCH;
      locked <= 1'b0;
    end else begin
      state  <= state_nxt;
      locked <= locked_nxt;
    end
  end

  // Lock FSM next state; the watchdog overrides any field-based transition
  always_comb begin
    state_nxt  = state;
    locked_nxt = 1'b0;
    if (vs_rise) begin
      case (state)
        SEARCH:  state_nxt = good_field ? ACQUIRE : SEARCH;
        ACQUIRE: state_nxt = good_field ? LOCKED  : SEARCH;
        LOCKED:  state_nxt = good_field ? LOCKED  : SEARCH;
        default: state_nxt = SEARCH;
      endcase
    end
    if ((h_nxt == H_MAX) || (v_nxt == V_MAX)) begin
      state_nxt = SEARCH;
    end
    locked_nxt = (state_nxt == LOCKED);
  end

  // Pixel output register; hsync blanks, enables load, otherwise hold
  always_ff @(posedge sysClock or negedge nReset) begin
    if (!nReset) begin
      active    <= 1'b0;
      pixelX    <= '0;
      pixelY    <= '0;
      red_out   <= '0;
      green_out <= '0;
      blue_out  <= '0;
    end else if (hsync) begin
      active    <= 1'b0;
      pixelX    <= '0;
      pixelY    <= '0;
      red_out   <= '0;
      green_out <= '0;
      blue_out  <= '0;
    end else if (pixelClockX1_en) begin
      active <= win_active;
      if (win_active) begin
        pixelX    <= h_count - HW'(H_ACTIVE_START);
        pixelY    <= v_count - VW'(V_ACTIVE_START);
        red_out   <= {6{redIn}};
        green_out <= {6{greenIn}};
        blue_out  <= {6{blueIn}};
      end else begin
        pixelX    <= '0;
        pixelY    <= '0;
        red_out   <= '0;
        green_out <= '0;
        blue_out  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_aiv_video_timing.sv
// Directed bench for aiv_video_timing: lock sequencing, field detection,
// active window, blanking and watchdog unlock.
module tb_aiv_video_timing;

  logic       sysClock = 1'b0;
  logic       nReset   = 1'b0;
  logic       en = 1'b0, hs = 1'b0, vs = 1'b0;
  logic       r = 1'b0, g = 1'b0, b = 1'b0;
  logic [5:0] red_out, green_out, blue_out;
  logic       active, field, locked;
  logic [9:0] pixelX;
  logic [8:0] pixelY;

  int n_chk = 0;
  int n_bad = 0;

  aiv_video_timing dut (
    .sysClock        (sysClock),
    .nReset          (nReset),
    .pixelClockX1_en (en),
    .hsync           (hs),
    .vsync           (vs),
    .redIn           (r),
    .greenIn         (g),
    .blueIn          (b),
    .red_out         (red_out),
    .green_out       (green_out),
    .blue_out        (blue_out),
    .active          (active),
    .pixelX          (pixelX),
    .pixelY          (pixelY),
    .field           (field),
    .locked          (locked)
  );

  always #5 sysClock = ~sysClock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One sysClock edge with the given controls; outputs are sampled #1 later
  task automatic tick(input logic e, input logic h, input logic v);
    en = e; hs = h; vs = v;
    @(posedge sysClock);
    #1;
  endtask

  task automatic plain_line();
    tick(1'b0, 1'b1, 1'b0);
    repeat (4) tick(1'b1, 1'b0, 1'b0);
  endtask

  // n hsyncs in total, then a vsync rise at hCount=rh (optionally with hsync)
  task automatic do_field(input int n, input int rh, input logic sim);
    repeat (n - 1) plain_line();
    tick(1'b0, 1'b1, 1'b0);
    repeat (rh) tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, sim, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset with random inputs
    repeat (4) begin
      r = 1'($urandom); g = 1'($urandom); b = 1'($urandom);
      tick(1'($urandom), 1'($urandom), 1'($urandom));
    end
    check("rst_red",    32'(red_out),   32'h0);
    check("rst_green",  32'(green_out), 32'h0);
    check("rst_blue",   32'(blue_out),  32'h0);
    check("rst_active", 32'(active),    32'h0);
    check("rst_px",     32'(pixelX),    32'h0);
    check("rst_py",     32'(pixelY),    32'h0);
    check("rst_field",  32'(field),     32'h0);
    check("rst_locked", 32'(locked),    32'h0);
    r = 1'b0; g = 1'b0; b = 1'b0;
    en = 1'b0; hs = 1'b0; vs = 1'b0;
    nReset = 1'b1;
    tick(1'b0, 1'b0, 1'b0);

    // Lock acquisition: SEARCH -> ACQUIRE -> LOCKED
    do_field(312, 10, 1'b0);
    check("acq_locked", 32'(locked), 32'h0);
    check("acq_field",  32'(field),  32'h0);
    do_field(312, 10, 1'b0);
    check("lock2_locked", 32'(locked), 32'h1);
    do_field(312, 10, 1'b0);
    check("lock3_locked", 32'(locked), 32'h1);
    check("lock3_field",  32'(field),  32'h0);

    // Alternating fields
    do_field(312, 400, 1'b0);
    check("alt1_field",  32'(field),  32'h1);
    check("alt1_locked", 32'(locked), 32'h1);
    do_field(312, 10, 1'b0);
    check("alt0_field",  32'(field),  32'h0);
    check("alt0_locked", 32'(locked), 32'h1);

    // Active window: vCount=23, hCount=120
    repeat (22) plain_line();
    tick(1'b0, 1'b1, 1'b0);
    repeat (120) tick(1'b1, 1'b0, 1'b0);
    check("pre_active", 32'(active), 32'h0);
    r = 1'b1;
    tick(1'b1, 1'b0, 1'b0);
    check("win_active", 32'(active),    32'h1);
    check("win_px",     32'(pixelX),    32'h0);
    check("win_py",     32'(pixelY),    32'h0);
    check("win_red",    32'(red_out),   32'h3f);
    check("win_green",  32'(green_out), 32'h0);
    r = 1'b0; g = 1'b1; b = 1'b1;
    tick(1'b1, 1'b0, 1'b0);
    check("win2_px",    32'(pixelX),    32'h1);
    check("win2_red",   32'(red_out),   32'h0);
    check("win2_green", 32'(green_out), 32'h3f);
    check("win2_blue",  32'(blue_out),  32'h3f);
    tick(1'b0, 1'b0, 1'b0);
    check("hold_active", 32'(active), 32'h1);
    check("hold_px",     32'(pixelX), 32'h1);
    repeat (638) tick(1'b1, 1'b0, 1'b0);
    check("last_px",     32'(pixelX), 32'd639);
    check("last_active", 32'(active), 32'h1);
    r = 1'b1;
    tick(1'b1, 1'b0, 1'b0);
    check("end_active", 32'(active),    32'h0);
    check("end_red",    32'(red_out),   32'h0);
    check("end_green",  32'(green_out), 32'h0);
    check("end_px",     32'(pixelX),    32'h0);

    // Next line, then hsync coinciding with an enable
    tick(1'b0, 1'b1, 1'b0);
    repeat (120) tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    check("l24_active", 32'(active), 32'h1);
    check("l24_py",     32'(pixelY), 32'h1);
    tick(1'b1, 1'b1, 1'b0);
    check("hsen_active", 32'(active),  32'h0);
    check("hsen_red",    32'(red_out), 32'h0);
    repeat (120) tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    check("hsen_px",  32'(pixelX), 32'h0);
    check("hsen_py",  32'(pixelY), 32'h2);
    check("hsen_act", 32'(active), 32'h1);
    r = 1'b0; g = 1'b0; b = 1'b0;

    // Bad field (300 lines) unlocks
    do_field(275, 10, 1'b0);
    check("bad300_locked", 32'(locked), 32'h0);

    // hsync coinciding with vsync rise at hCount=400: field 0, vCount cleared
    do_field(312, 400, 1'b1);
    check("sim_field",  32'(field),  32'h0);
    check("sim_locked", 32'(locked), 32'h0);
    do_field(314, 10, 1'b0);
    check("max314_locked", 32'(locked), 32'h1);
    do_field(310, 10, 1'b0);
    check("min310_locked", 32'(locked), 32'h1);
    do_field(315, 10, 1'b0);
    check("bad315_locked", 32'(locked), 32'h0);
    do_field(309, 10, 1'b0);
    check("bad309_locked", 32'(locked), 32'h0);
    do_field(312, 10, 1'b0);
    do_field(312, 10, 1'b0);
    check("relock_locked", 32'(locked), 32'h1);

    // Hsync lost: hCount 10 -> 1023 after 1013 enables
    repeat (1012) tick(1'b1, 1'b0, 1'b0);
    check("wd_pre_locked", 32'(locked), 32'h1);
    tick(1'b1, 1'b0, 1'b0);
    check("wd_locked", 32'(locked), 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
